// File: rtl/sensor_request.sv
// sensor_request: per-lane synchronise, debounce, request latch and wait-seconds counter for the traffic FSM.
module sensor_request #(
  parameter int N_SENSORS      = 3,
  parameter int DEBOUNCE_TICKS = 200,
  parameter bit ACTIVE_HIGH    = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   tick_1s,
  input  logic [N_SENSORS-1:0]   sensor_raw,
  input  logic [N_SENSORS-1:0]   ack,
  output logic [N_SENSORS-1:0]   presence,
  output logic [N_SENSORS-1:0]   request,
  output logic                   any_request,
  output logic [8*N_SENSORS-1:0] wait_sec
);
  localparam int CW = $clog2(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_TICKS - 1);
  typedef enum logic [1:0] {IDLE, QUAL_ON, PRESENT, QUAL_OFF} state_t;
  logic [N_SENSORS-1:0] s_raw, sync1, s, next_req;
  assign s_raw = sensor_raw ^ {N_SENSORS{~ACTIVE_HIGH}};
  always_ff @(posedge clk or negedge reset)
    if (!reset) {s, sync1} <= '0;
    else {s, sync1} <= {sync1, s_raw};
  always_ff @(posedge clk or negedge reset)
    if (!reset) any_request <= 1'b0;
    else any_request <= |next_req;
  for (genvar i = 0; i < N_SENSORS; i++) begin : ch
    state_t state;
    logic [CW-1:0] cnt;
    logic pres, req, rise;
    logic [7:0] w;
    // rise is the QUAL_ON -> PRESENT transition taken on this edge
    assign rise = state == QUAL_ON && s[i] && cnt == LAST;
    assign next_req[i] = enable && (rise || (!ack[i] && req));
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        state <= IDLE;
        cnt   <= '0;
        pres  <= 1'b0;
      end else
        case (state)
          IDLE:
            if (s[i]) begin
              state <= QUAL_ON;
              cnt   <= CW'(1);
            end
          QUAL_ON:
            if (!s[i]) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == LAST) begin
              state <= PRESENT;
              cnt   <= '0;
              pres  <= 1'b1;
            end else cnt <= cnt + 1'b1;
          PRESENT:
            if (!s[i]) begin
              state <= QUAL_OFF;
              cnt   <= CW'(1);
            end
          QUAL_OFF:
            if (s[i]) begin
              state <= PRESENT;
              cnt   <= '0;
            end else if (cnt == LAST) begin
              state <= IDLE;
              cnt   <= '0;
              pres  <= 1'b0;
            end else cnt <= cnt + 1'b1;
        endcase
    // wait restarts from 0 whenever the request is newly set or dropped
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        req <= 1'b0;
        w   <= '0;
      end else begin
        req <= next_req[i];
        w   <= (!next_req[i] || !req) ? '0 : (tick_1s && w != 8'hff) ? w + 8'd1 : w;
      end
    assign presence[i]       = pres;
    assign request[i]        = req;
    assign wait_sec[8*i +: 8] = w;
  end
endmodule

// File: tb/tb_sensor_request.sv
// tb_sensor_request: randomized and directed stimulus checked against a run-length behavioural model.
module tb_sensor_request;
  localparam int N  = 3;
  localparam int DT = 4;
  logic clk = 0, reset = 0, enable = 0, tick_1s = 0;
  logic [N-1:0] sensor_raw = '0, ack = '0, presence, request;
  logic any_request;
  logic [8*N-1:0] wait_sec;
  int tests = 0, fails = 0;
  logic [N-1:0] m_s1, m_s2;
  int run[N], m_wait[N];
  bit m_pres[N], m_req[N];
  int hold[N];

  sensor_request #(.N_SENSORS(N), .DEBOUNCE_TICKS(DT), .ACTIVE_HIGH(1'b1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .tick_1s(tick_1s),
    .sensor_raw(sensor_raw), .ack(ack), .presence(presence), .request(request),
    .any_request(any_request), .wait_sec(wait_sec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0;
    m_s2 = '0;
    for (int i = 0; i < N; i++) begin
      run[i] = 0; m_wait[i] = 0; m_pres[i] = 0; m_req[i] = 0;
    end
  endtask

  // presence flips after DT consecutive synchronised samples disagreeing with it
  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      bit sv, was, rise, nreq;
      sv = m_s2[i];
      was = m_pres[i];
      run[i] = (sv != m_pres[i]) ? run[i] + 1 : 0;
      if (run[i] == DT) begin
        m_pres[i] = sv;
        run[i] = 0;
      end
      rise = m_pres[i] && !was;
      nreq = !enable ? 0 : rise ? 1 : ack[i] ? 0 : m_req[i];
      m_wait[i] = (!nreq || !m_req[i]) ? 0 : tick_1s ? ((m_wait[i] + 1 > 255) ? 255 : m_wait[i] + 1) : m_wait[i];
      m_req[i] = nreq;
    end
    m_s2 = m_s1;
    m_s1 = sensor_raw;
  endtask

  task automatic compare();
    logic [N-1:0] ep, er;
    logic [8*N-1:0] ew;
    for (int i = 0; i < N; i++) begin
      ep[i] = m_pres[i];
      er[i] = m_req[i];
      ew[8*i +: 8] = 8'(m_wait[i]);
    end
    chk("presence", 32'(presence), 32'(ep));
    chk("request", 32'(request), 32'(er));
    chk("any_request", 32'(any_request), 32'(|er));
    chk("wait_sec", 32'(wait_sec), 32'(ew));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < N; i++) begin
      if (hold[i] == 0) begin
        sensor_raw[i] = 1'($urandom_range(0, 1));
        hold[i] = $urandom_range(1, 8);
      end
      hold[i]--;
      ack[i] = ($urandom_range(0, 9) == 0);
    end
    enable  = ($urandom_range(0, 49) != 0);
    tick_1s = ($urandom_range(0, 2) == 0);
  endtask

  initial begin
    int n;
    model_reset();
    for (int i = 0; i < N; i++) hold[i] = 0;
    repeat (2) @(negedge clk);
    compare();
    reset = 1;
    enable = 1;
    // directed latency: first sampled at edge 1, presence/request at edge 6
    sensor_raw = 3'b001;
    n = 0;
    for (int k = 1; k <= 20 && n == 0; k++) begin
      cycle();
      if (presence[0]) n = k;
    end
    chk("latency_edges", 32'(n), 32'd6);
    chk("latency_req", 32'(request), 32'b001);
    // random traffic
    for (int k = 0; k < 1500; k++) begin
      rand_inputs();
      cycle();
    end
    // wait counter saturation on channel 1
    ack = '0; enable = 1; tick_1s = 0; sensor_raw = '0;
    repeat (10) cycle();
    sensor_raw = 3'b010;
    tick_1s = 1;
    repeat (310) cycle();
    chk("wait_sat", 32'(wait_sec[15:8]), 32'd255);
    enable = 0;
    cycle();
    chk("wait_drop", 32'(wait_sec[15:8]), 32'd0);
    enable = 1; tick_1s = 0;
    // set/clear collision on channel 0 with ack held high
    sensor_raw = '0;
    repeat (10) cycle();
    ack = 3'b001;
    sensor_raw = 3'b001;
    repeat (12) cycle();
    ack = '0;
    // async reset mid-request and mid-qualification
    sensor_raw = 3'b111; tick_1s = 1;
    repeat (20) cycle();
    sensor_raw = 3'b110;
    repeat (8) cycle();
    sensor_raw = 3'b111;
    repeat (3) cycle();
    #2 reset = 0;
    #1;
    model_reset();
    compare();
    #1 reset = 1;
    tick_1s = 0;
    n = 0;
    for (int k = 1; k <= 20 && n == 0; k++) begin
      cycle();
      if (presence[0]) n = k;
    end
    chk("requal_edges", 32'(n), 32'd6);
    for (int k = 0; k < 500; k++) begin
      rand_inputs();
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sensor_request.md
Name: sensor_request

Overview:
- Writer side of the vehicle-sensor interface consumed by the main traffic FSM (SNN, SNS, STH inputs).
- Conditions raw loop-detector pins per lane: synchronise, debounce, latch a service request, hold it until the FSM acknowledges, and report time waiting.
- Sits between the sensor gpios and the fsm, clocked from the 10 kHz low-frequency oscillator domain.

Parameters:
- N_SENSORS, 3, number of independent sensor channels (bit 0 = TH, 1 = NN, 2 = NS).
- DEBOUNCE_TICKS, 200, consecutive stable clk samples required to change presence (20 ms at 10 kHz); legal range 2..65535.
- ACTIVE_HIGH, 1, 1: raw pin high = vehicle present; 0: raw pin low = vehicle present.

Ports:
- clk  input  1  system clock (10 kHz).
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  global enable, same signal that drives the fsm enable.
- tick_1s  input  1  one-clk pulse per second from the timing block.
- sensor_raw  input  N_SENSORS  asynchronous detector pins.
- ack  input  N_SENSORS  per-channel pulse or level from the fsm: phase served, clear request.
- presence  output  N_SENSORS  debounced vehicle-present level.
- request  output  N_SENSORS  latched service request.
- any_request  output  1  OR of request bits.
- wait_sec  output  8*N_SENSORS  per-channel seconds waited. Channel i occupies bits [8i+7:8i].

Behaviour:
- Reset (reset=0, async): sync flops hold the inactive level. All debounce FSMs go to IDLE with counters at 0. presence=0, request=0, any_request=0, wait_sec=0. Asserting reset mid-qualification or mid-request discards all state. Outputs are released on the first clk edge after reset goes high.
- Normalisation: s_raw = sensor_raw XOR ~ACTIVE_HIGH, then a 2-FF synchroniser per channel. The synchronised sample is s.
- Debounce FSM per channel:
  - States: IDLE (presence 0), QUAL_ON, PRESENT (presence 1), QUAL_OFF.
  - Counter width is clog2(DEBOUNCE_TICKS).
  - IDLE: s=1 -> QUAL_ON, cnt=1.
  - QUAL_ON: s=0 -> IDLE, cnt=0. s=1 and cnt==DEBOUNCE_TICKS-1 -> PRESENT, cnt=0. Otherwise cnt++.
  - PRESENT: s=0 -> QUAL_OFF, cnt=1.
  - QUAL_OFF: s=1 -> PRESENT, cnt=0. s=0 and cnt==DEBOUNCE_TICKS-1 -> IDLE, cnt=0. Otherwise cnt++.
  - presence is registered and equals (state==PRESENT or state==QUAL_OFF).
  - Latency: if the first edge sampling the raw pin active is edge E and the pin stays active, presence rises at edge E+DEBOUNCE_TICKS+1. The falling edge of presence follows the same rule.
  - Any pulse shorter than DEBOUNCE_TICKS samples never changes presence.
- Debounce runs regardless of enable.
- Request latch per channel:
  - rise = presence goes 0->1 on this edge (the PRESENT entry transition).
  - enable=0: request cleared, no sets.
  - enable=1: rise sets request. Otherwise ack=1 clears it. Otherwise it holds.
  - Simultaneous rise and ack: set wins, request stays 1.
  - ack while request=0: no effect.
  - A vehicle staying present does not re-request after an ack; only a new rise does.
- any_request is registered: the OR of the next-state request bits, so it matches request in the same cycle.
- wait_sec per channel:
  - Cleared to 0 on the edge where request becomes 0, or when it is 0.
  - While request=1 and tick_1s=1: increment, saturating at 255 (no wrap).
  - On the edge where request sets, wait_sec is 0 even if tick_1s=1.
- Channels are fully independent. No cross-channel priority in this block.

Test Plan:
- DEBOUNCE_TICKS=4, enable=1. Raise sensor_raw[0] (active high), first sampled at edge 1, and hold -> presence[0]=1 and request[0]=1 at edge 6, any_request=1. Channels 1 and 2 stay 0.
- Glitch: sensor_raw[1] high for 3 clks, then low -> presence[1] and request[1] never assert, and the channel FSM returns to IDLE.
- Handshake: request[2]=1, pulse ack[2] for 1 clk -> request[2]=0 at the next edge and wait_sec[23:16]=0. Vehicle still present -> no new request. Release for ≥6 clks, re-present -> request[2]=1 again 5 clks after the re-press is first sampled.
- Set/clear collision: ack[0]=1 held continuously while a new rise on channel 0 occurs -> request[0]=1 on that edge. Cleared on the following edge because ack is still 1.
- Wait counter: request[1]=1 with 300 tick_1s pulses -> wait_sec[15:8] counts 1..255 and stays at 255. Drop enable -> request[1]=0 and wait_sec[15:8]=0 at the next edge.
- Async reset: assert reset=0 mid-QUAL_ON with request[0]=1 and wait_sec[7:0]=7 -> all outputs 0 immediately, without a clk edge. After release, raw still high -> presence[0] asserts after a full DEBOUNCE_TICKS+1 requalification.
